// File: rtl/counter_seq_ctrl.sv
// Run controller for a looping 0..max counter: idle/run/pause/done sequencing,
// programmable wrap limit and loop count, registered wrap/done pulses.
module counter_seq_ctrl #(
  parameter int unsigned W      = 6,
  parameter int unsigned DEF_MX = 30,
  parameter int unsigned LW     = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_valid,
  input  logic [W-1:0]  cfg_max,
  input  logic [LW-1:0] cfg_loops,
  output logic          cfg_ready,
  input  logic          start,
  input  logic          pause,
  input  logic          stop,
  output logic [W-1:0]  count,
  output logic          wrap,
  output logic          done,
  output logic          busy,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  mx_q, mx_d;
  logic [LW-1:0] loops_q, loops_d;
  logic [LW-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] wcnt_inc;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic          cfg_acc;

  // Ready is decoded from registered state only, so a config offered during a
  // run simply waits until the run ends.
  assign cfg_ready = (state_q == S_IDLE) || (state_q == S_DONE);
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign wcnt_inc  = wcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wcnt_d  = wcnt_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;
    mx_d    = cfg_acc ? cfg_max   : mx_q;
    loops_d = cfg_acc ? cfg_loops : loops_q;

    unique case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (!stop && start) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
          wcnt_d  = '0;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (count_q != mx_q) begin
          count_d = count_q + 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
          wcnt_d  = wcnt_inc;
          // Loop count of zero means the run never terminates on its own.
          if ((loops_q != '0) && (wcnt_inc == loops_q)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          count_d = '0;
          wcnt_d  = '0;
        end else if (!pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        count_d = '0;
        if (stop) begin
          state_d = S_IDLE;
        end else if (start) begin
          state_d = S_RUN;
          wcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      mx_q    <= W'(DEF_MX);
      loops_q <= '0;
      wcnt_q  <= '0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mx_q    <= mx_d;
      loops_q <= loops_d;
      wcnt_q  <= wcnt_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign done  = done_q;
  assign busy  = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign state = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: per-cycle expected observations are queued when
// stimulus is planned and popped against the DUT after each rising edge.
module tb_counter_seq_ctrl;

  localparam int W  = 6;
  localparam int LW = 4;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic [W-1:0]  cfg_max;
  logic [LW-1:0] cfg_loops;
  logic          cfg_ready;
  logic          start, pause, stop;
  logic [W-1:0]  count;
  logic          wrap, done, busy;
  logic [1:0]    state;

  typedef struct packed {
    logic [1:0]   st;
    logic [W-1:0] cnt;
    logic         wr;
    logic         dn;
    logic         bz;
    logic         rdy;
  } obs_t;

  obs_t sb[$];
  obs_t e, a;
  int   checks   = 0;
  int   failures = 0;

  counter_seq_ctrl #(.W(W), .DEF_MX(30), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_max   (cfg_max),
    .cfg_loops (cfg_loops),
    .cfg_ready (cfg_ready),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .count     (count),
    .wrap      (wrap),
    .done      (done),
    .busy      (busy),
    .state     (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  function automatic obs_t mk(input logic [1:0] st, input int c, input logic wr, input logic dn);
    obs_t o;
    o.st  = st;
    o.cnt = W'(c);
    o.wr  = wr;
    o.dn  = dn;
    o.bz  = (st == S_RUN) || (st == S_PAUSE);
    o.rdy = (st == S_IDLE) || (st == S_DONE);
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d cnt=%0d wrap=%0b done=%0b busy=%0b rdy=%0b",
                     o.st, o.cnt, o.wr, o.dn, o.bz, o.rdy);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; cfg_valid = 1'b0; cfg_max = '0; cfg_loops = '0;
    start = 1'b0; pause = 1'b0; stop = 1'b0;
    for (int i = 0; i < 3; i++) sb.push_back(mk(S_IDLE, 0, 1'b0, 1'b0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      rst = (i < 2);
      tick();
      e = sb.pop_front();
      a = {state, count, wrap, done, busy, cfg_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL reset step=%0d actual %s required %s", i, fmt(a), fmt(e));
      end
    end
  endtask

  task automatic test_default_run();
    int n;
    for (int i = 0; i < 100; i++)
      sb.push_back(mk(S_RUN, i % 31, (i > 0) && (i % 31 == 0), 1'b0));
    sb.push_back(mk(S_IDLE, 0, 1'b0, 1'b0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      start = (i == 0);
      stop  = (i == 100);
      tick();
      e = sb.pop_front();
      a = {state, count, wrap, done, busy, cfg_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL default_run step=%0d actual %s required %s", i, fmt(a), fmt(e));
      end
    end
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic test_bounded();
    int n;
    sb.push_back(mk(S_IDLE, 0, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++)
      sb.push_back(mk((i >= 8) ? S_DONE : S_RUN, (i >= 8) ? 0 : i % 4,
                      (i == 4) || (i == 8), (i == 8)));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      cfg_valid = (i == 0); cfg_max = 6'd3; cfg_loops = 4'd2;
      start = (i == 1);
      tick();
      e = sb.pop_front();
      a = {state, count, wrap, done, busy, cfg_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL bounded step=%0d actual %s required %s", i, fmt(a), fmt(e));
      end
    end
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_pause_boundary();
    int n;
    for (int i = 0; i < 15; i++) begin
      if (i <= 3)       sb.push_back(mk(S_RUN, i, 1'b0, 1'b0));
      else if (i <= 8)  sb.push_back(mk(S_PAUSE, 3, 1'b0, 1'b0));
      else if (i == 9)  sb.push_back(mk(S_RUN, 3, 1'b0, 1'b0));
      else if (i == 10) sb.push_back(mk(S_RUN, 0, 1'b1, 1'b0));
      else if (i <= 13) sb.push_back(mk(S_RUN, i - 10, 1'b0, 1'b0));
      else              sb.push_back(mk(S_DONE, 0, 1'b1, 1'b1));
    end
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      start = (i == 0);
      pause = (i >= 4) && (i <= 8);
      tick();
      e = sb.pop_front();
      a = {state, count, wrap, done, busy, cfg_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL pause_boundary step=%0d actual %s required %s", i, fmt(a), fmt(e));
      end
    end
    start = 1'b0; pause = 1'b0;
  endtask

  task automatic test_stop_priority();
    int n;
    for (int i = 0; i < 17; i++) begin
      if (i <= 6)       sb.push_back(mk(S_RUN, i % 4, (i == 4), 1'b0));
      else if (i == 7)  sb.push_back(mk(S_IDLE, 0, 1'b0, 1'b0));
      else if (i <= 15) sb.push_back(mk(S_RUN, (i - 8) % 4, (i == 12), 1'b0));
      else              sb.push_back(mk(S_DONE, 0, 1'b1, 1'b1));
    end
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      start = (i == 0) || (i == 8);
      stop  = (i == 7);
      pause = (i == 7);
      tick();
      e = sb.pop_front();
      a = {state, count, wrap, done, busy, cfg_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL stop_priority step=%0d actual %s required %s", i, fmt(a), fmt(e));
      end
    end
    start = 1'b0; stop = 1'b0; pause = 1'b0;
  endtask

  task automatic test_cfg_gating();
    int n;
    for (int i = 0; i < 14; i++) begin
      if (i <= 7)       sb.push_back(mk(S_RUN, i % 4, (i == 4), 1'b0));
      else if (i == 8)  sb.push_back(mk(S_DONE, 0, 1'b1, 1'b1));
      else if (i == 9)  sb.push_back(mk(S_RUN, 0, 1'b0, 1'b0));
      else if (i <= 11) sb.push_back(mk(S_RUN, 0, 1'b1, 1'b0));
      else if (i == 12) sb.push_back(mk(S_DONE, 0, 1'b1, 1'b1));
      else              sb.push_back(mk(S_DONE, 0, 1'b0, 1'b0));
    end
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      start     = (i == 0) || (i == 9);
      cfg_valid = (i >= 1) && (i <= 9);
      cfg_max   = 6'd0;
      cfg_loops = 4'd3;
      tick();
      e = sb.pop_front();
      a = {state, count, wrap, done, busy, cfg_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cfg_gating step=%0d actual %s required %s", i, fmt(a), fmt(e));
      end
    end
    start = 1'b0; cfg_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    int n;
    for (int i = 0; i < 18; i++) sb.push_back(mk(S_RUN, i, 1'b0, 1'b0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      start     = (i == 0);
      cfg_valid = (i == 0);
      cfg_max   = 6'd20;
      cfg_loops = 4'd1;
      tick();
      e = sb.pop_front();
      a = {state, count, wrap, done, busy, cfg_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL async_pre step=%0d actual %s required %s", i, fmt(a), fmt(e));
      end
    end
    start = 1'b0; cfg_valid = 1'b0;
    // Reset lands between edges; outputs must clear before any clock.
    sb.push_back(mk(S_IDLE, 0, 1'b0, 1'b0));
    #2 rst = 1'b1;
    #1;
    e = sb.pop_front();
    a = {state, count, wrap, done, busy, cfg_ready};
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL async_clear actual %s required %s", fmt(a), fmt(e));
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++)
      sb.push_back(mk(S_RUN, i % 31, (i == 31), 1'b0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      start = (i == 0);
      tick();
      e = sb.pop_front();
      a = {state, count, wrap, done, busy, cfg_ready};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL async_post step=%0d actual %s required %s", i, fmt(a), fmt(e));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_bounded();
    test_pause_boundary();
    test_stop_priority();
    test_cfg_gating();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
